// File: rtl/decode_pkg.sv
// decode_pkg: RV32 base opcodes and the 3-bit format encoding shared by the decode stage
package decode_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_t;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: instruction[31:7] + fmt -> XLEN-wide immediate sign-extended from instruction[31]
module imm_gen import decode_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instruction,
  input  fmt_t            fmt,
  output logic [XLEN-1:0] imm
);
  logic [31:0] v;
  always_comb
    v = fmt == FMT_I ? {{20{instruction[31]}}, instruction[31:20]} :
        fmt == FMT_S ? {{20{instruction[31]}}, instruction[31:25], instruction[11:7]} :
        fmt == FMT_B ? {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0} :
        fmt == FMT_U ? {instruction[31:12], 12'b0} :
        fmt == FMT_J ? {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0} :
        32'd0;
  assign imm = XLEN'($signed(v));
endmodule

// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: registered RISC-V decode (fields, fmt, imm, illegal) with valid/ready on both sides and flush
module instruction_decode_stage import decode_pkg::*; #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output fmt_t            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_d;
  logic [6:0]      op;
  fmt_t            fmt_d;
  assign op = instruction[6:0];
  always_comb
    fmt_d = op == OP_R                                         ? FMT_R :
            (op == OP_IMM || op == OP_LOAD || op == OP_JALR)   ? FMT_I :
            op == OP_STORE                                     ? FMT_S :
            op == OP_BRANCH                                    ? FMT_B :
            (op == OP_LUI || op == OP_AUIPC)                   ? FMT_U :
            op == OP_JAL                                       ? FMT_J :
            FMT_ILL;
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instruction(instruction[31:7]),
    .fmt        (fmt_d),
    .imm        (imm_d)
  );
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      instr_q   <= '0;
      pc_q      <= RESET_PC;
      fmt       <= FMT_R;
      imm       <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      instr_q   <= instruction;
      pc_q      <= in_pc;
      fmt       <= fmt_d;
      imm       <= imm_d;
      illegal   <= fmt_d == FMT_ILL || instruction[1:0] != 2'b11;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  assign {funct7, rs2, rs1, funct3, rd, opcode} = instr_q;
  assign out_pc = out_valid ? pc_q : RESET_PC;
endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb_instruction_decode_stage: directed + random scoreboard bench for XLEN=32 and XLEN=64 decode stages
module tb_instruction_decode_stage;
  import decode_pkg::*;
  localparam logic [31:0] RPC    = 32'h0000_0080;
  localparam logic [63:0] RPC64  = 64'h0000_0000_0000_0200;
  localparam logic [31:0] PC_HI  = 32'hA5A5_0000;
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    fmt_t        f;
    logic [63:0] imm;
    logic        ill;
  } exp_t;
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    fmt_t        f;
    logic [4:0]  rd;
    logic [12:0] src;
    logic [63:0] imm;
    logic        ill;
  } dir_t;
  logic clk = 0, reset = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] instruction = 0, in_pc = 0;
  logic in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm;
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  fmt_t fmt;
  logic in_ready64, out_valid64, illegal64;
  logic [63:0] out_pc64, imm64;
  logic [6:0] opcode64, funct7_64;
  logic [4:0] rd64, rs1_64, rs2_64;
  logic [2:0] funct3_64;
  fmt_t fmt64;
  int passed = 0, total = 0, delivered = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  instruction_decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .fmt(fmt), .imm(imm), .illegal(illegal)
  );
  instruction_decode_stage #(.XLEN(64), .RESET_PC(RPC64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .instruction(instruction), .in_pc({PC_HI, in_pc}), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
    .opcode(opcode64), .rd(rd64), .funct3(funct3_64), .rs1(rs1_64), .rs2(rs2_64),
    .funct7(funct7_64), .fmt(fmt64), .imm(imm64), .illegal(illegal64)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] pc);
    exp_t e;
    longint s, v;
    s = x[31] ? 1 : 0;
    v = 0;
    case (x[6:0])
      7'h33: e.f = FMT_R;
      7'h13, 7'h03, 7'h67: begin e.f = FMT_I; v = longint'(x[30:20]) - s * 2048; end
      7'h23: begin e.f = FMT_S; v = longint'(x[30:25]) * 32 + longint'(x[11:7]) - s * 2048; end
      7'h63: begin e.f = FMT_B; v = longint'(x[7]) * 2048 + longint'(x[30:25]) * 32 + longint'(x[11:8]) * 2 - s * 4096; end
      7'h37, 7'h17: begin e.f = FMT_U; v = longint'(x[30:12]) * 4096 - s * (longint'(1) << 31); end
      7'h6f: begin e.f = FMT_J; v = longint'(x[19:12]) * 4096 + longint'(x[20]) * 2048 + longint'(x[30:21]) * 2 - s * (longint'(1) << 20); end
      default: e.f = FMT_ILL;
    endcase
    e.ins = x;
    e.pc  = pc;
    e.imm = v;
    e.ill = e.f == FMT_ILL;
    return e;
  endfunction
  function automatic logic [31:0] rand_ins();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h0b};
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 10);
    return k == 10 ? r : {r[31:7], ops[k]};
  endfunction
  always @(negedge clk) begin
    bit acc;
    if (reset) q.delete();
    else begin
      chk("in_ready", in_ready, q.size() == 0 || out_ready);
      chk("in_ready64", in_ready64, q.size() == 0 || out_ready);
      chk("out_valid", out_valid, q.size() != 0);
      chk("out_valid64", out_valid64, q.size() != 0);
      if (q.size() != 0) begin
        chk("fields", {funct7, rs2, rs1, funct3, rd, opcode}, q[0].ins);
        chk("fields64", {funct7_64, rs2_64, rs1_64, funct3_64, rd64, opcode64}, q[0].ins);
        chk("out_pc", out_pc, q[0].pc);
        chk("out_pc64", out_pc64, {PC_HI, q[0].pc});
        chk("fmt", fmt, q[0].f);
        chk("fmt64", fmt64, q[0].f);
        chk("imm", imm, q[0].imm[31:0]);
        chk("imm64", imm64, q[0].imm);
        chk("illegal", illegal, q[0].ill);
        chk("illegal64", illegal64, q[0].ill);
      end
      acc = in_valid && (q.size() == 0 || out_ready);
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && out_ready) begin
          void'(q.pop_front());
          delivered++;
        end
        if (acc) q.push_back(model(instruction, in_pc));
      end
    end
  end
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid = v;
    instruction = ins;
    in_pc = pc;
    out_ready = r;
    flush = f;
  endtask
  initial begin
    dir_t d [7] = '{
      '{32'hFFF00093, 32'h100, FMT_I,   5'd1, 13'h1F00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0},
      '{32'h0020A423, 32'h104, FMT_S,   5'd8, 13'h020A, 64'h0000_0000_0000_0008, 1'b0},
      '{32'hFE000EE3, 32'h108, FMT_B,   5'd29, 13'h0000, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0},
      '{32'h123452B7, 32'h10C, FMT_U,   5'd5, 13'h0345, 64'h0000_0000_1234_5000, 1'b0},
      '{32'h00000000, 32'h110, FMT_ILL, 5'd0, 13'h0000, 64'h0000_0000_0000_0000, 1'b1},
      '{32'hFF9FF06F, 32'h114, FMT_J,   5'd0, 13'h19FF, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0},
      '{32'h002081B3, 32'h118, FMT_R,   5'd3, 13'h0208, 64'h0000_0000_0000_0000, 1'b0}
    };
    int base;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", {funct7, rs2, rs1, funct3, rd, opcode}, 0);
    chk("rst_fmt_imm_ill", {fmt, imm, illegal}, 0);
    chk("rst_out_pc", out_pc, RPC);
    chk("rst_out_pc64", out_pc64, RPC64);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 reset = 0;
    foreach (d[i]) begin
      drive(1, d[i].ins, d[i].pc, 1, 0);
      drive(0, 0, 0, 1, 0);
      chk("dir_valid", out_valid, 1);
      chk("dir_fmt", fmt, d[i].f);
      chk("dir_rd", rd, d[i].rd);
      chk("dir_src", {rs2, rs1, funct3}, d[i].src);
      chk("dir_imm", imm, d[i].imm[31:0]);
      chk("dir_imm64", imm64, d[i].imm);
      chk("dir_illegal", illegal, d[i].ill);
      chk("dir_out_pc", out_pc, d[i].pc);
    end
    drive(1, 32'h00500113, 32'h200, 0, 0);
    drive(1, 32'h00A00193, 32'h204, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_in_ready", in_ready, 0);
      chk("stall_rd", rd, 5'd2);
      @(posedge clk);
    end
    base = delivered;
    drive(1, 32'h00A00193, 32'h204, 1, 0);
    drive(1, 32'h0041A223, 32'h208, 1, 0);
    drive(1, 32'h00208463, 32'h20C, 1, 0);
    drive(1, 32'h000012B7, 32'h210, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("burst_delivered", delivered - base, 5);
    drive(1, 32'h00100093, 32'h300, 0, 0);
    drive(1, 32'h00200113, 32'h304, 1, 1);
    drive(0, 0, 0, 1, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_valid64", out_valid64, 0);
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(0, 9) < 7, rand_ins(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    drive(1, 32'hFFF00093, 32'h400, 0, 0);
    drive(1, 32'h00100093, 32'h404, 0, 0);
    #1 reset = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_fields", {funct7, rs2, rs1, funct3, rd, opcode}, 0);
    chk("midrst_fmt_imm_ill", {fmt, imm, illegal}, 0);
    chk("midrst_out_pc", out_pc, RPC);
    chk("midrst_imm64", imm64, 0);
    drive(0, 0, 0, 1, 0);
    reset = 0;
    for (int i = 0; i < 20 && q.size() != 0; i++) drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("drain_out_valid", out_valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
